tlb_op_ctrl: RTL

//  Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the shared TLB array in the MMU.
//  - Accepts one op at a time from the memory stage and stalls the pipeline while busy.
//  - Drives TLB write/read/probe controls and returns results as CP0 register write-enables.
//  - Owns the CP0 Random and Wired registers.

---
 rtl/translation_pkg.sv | 31 +++
 rtl/tlb_random_ctr.sv | 44 ++++
 rtl/tlb_op_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/translation_pkg.sv
// translation_pkg
//   Shared types and constants for the CP0 TLB instruction sequencer.
//   - TLB_ENTRIES / IW : default TLB depth and index width
//   - tlb_addr_t       : one TLB entry address
//   - tlb_op_t         : encoding of op_type from the memory stage
//   - tlb_op_state_t   : sequencer FSM states (PROBE_REG is only reached
//                        when TLB_OP_REG_PROBE_EN is defined)
package translation_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int IW          = $clog2(TLB_ENTRIES);

  typedef logic [IW-1:0] tlb_addr_t;

  typedef enum logic [1:0] {
    TLBP  = 2'b00,
    TLBR  = 2'b01,
    TLBWI = 2'b10,
    TLBWR = 2'b11
  } tlb_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROBE     = 3'd1,
    PROBE_REG = 3'd2,
    READ      = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } tlb_op_state_t;

endpackage

// File: rtl/tlb_random_ctr.sv
// tlb_random_ctr
//   Owns the CP0 Random and Wired registers. Random counts down every
//   cycle and wraps back to TLB_ENTRIES-1 once it is at or below Wired,
//   so it only ever visits the non-wired entries. Writing Wired reloads
//   Random to the top in the same cycle.
// Ports
//   clk, resetn  : clock, asynchronous active-low reset
//   wired_we     : MTC0 Wired strobe
//   wired_wdata  : new Wired value
//   random       : current CP0 Random
//   wired        : current CP0 Wired
module tlb_random_ctr
  import translation_pkg::*;
#(
  parameter int   TLB_ENTRIES = translation_pkg::TLB_ENTRIES,
  localparam int  IW          = $clog2(TLB_ENTRIES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wired_we,
  input  logic [IW-1:0] wired_wdata,
  output logic [IW-1:0] random,
  output logic [IW-1:0] wired
);

  localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

  // A Wired write takes priority over the normal decrement. The <= test
  // also pins Random at the top when Wired itself is TLB_ENTRIES-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random <= TOP;
      wired  <= '0;
    end else if (wired_we) begin
      wired  <= wired_wdata;
      random <= TOP;
    end else if (random <= wired) begin
      random <= TOP;
    end else begin
      random <= random - IW'(1);
    end
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl
//   Sequences TLBP / TLBR / TLBWI / TLBWR against the shared MMU TLB array,
//   one op at a time, stalling the pipeline through busy while active.
//   Flow: IDLE -> PROBE | READ | WRITE -> DONE -> IDLE.
// Configuration
//   TLB_OP_REG_PROBE_EN : when defined, PROBE spends an extra cycle
//                         (PROBE_REG) and samples the probe port in the
//                         second cycle, easing the CAM lookup path.
// Ports
//   clk, resetn              : clock, asynchronous active-low reset
//   op_valid/op_type/op_ready: op handshake from the memory stage
//   flush                    : exception/ERET flush
//   cp0_index                : CP0 Index.index
//   wired_we/wired_wdata     : MTC0 Wired
//   probe_hit/probe_index    : TLB probe-port lookup result
//   tlbw_valid/tlbw_addr     : TLB write strobe and address
//   tlbra                    : TLB read address
//   index_we/index_wdata     : CP0 Index write {P, index}
//   entry_we                 : load EntryHi/Lo0/Lo1 from TLB read data
//   random/wired             : CP0 Random / Wired
//   busy                     : pipeline stall
//   op_done                  : one-cycle completion pulse
module tlb_op_ctrl
  import translation_pkg::*;
#(
  parameter int   TLB_ENTRIES = translation_pkg::TLB_ENTRIES,
  localparam int  IW          = $clog2(TLB_ENTRIES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_type,
  output logic          op_ready,
  input  logic          flush,
  input  logic [IW-1:0] cp0_index,
  input  logic          wired_we,
  input  logic [IW-1:0] wired_wdata,
  input  logic          probe_hit,
  input  logic [IW-1:0] probe_index,
  output logic          tlbw_valid,
  output logic [IW-1:0] tlbw_addr,
  output logic [IW-1:0] tlbra,
  output logic          index_we,
  output logic [IW:0]   index_wdata,
  output logic          entry_we,
  output logic [IW-1:0] random,
  output logic [IW-1:0] wired,
  output logic          busy,
  output logic          op_done
);

  tlb_op_state_t state_q, state_d;
  tlb_op_t       op_q;
  logic [IW-1:0] waddr_q;
  logic [IW-1:0] tlbra_q;
  logic          hit_q;
  logic [IW-1:0] hit_idx_q;
  logic          suppress_q;
  logic          accept;

`ifdef TLB_OP_REG_PROBE_EN
  localparam tlb_op_state_t PROBE_SAMPLE = PROBE_REG;
`else
  localparam tlb_op_state_t PROBE_SAMPLE = PROBE;
`endif

  tlb_random_ctr #(.TLB_ENTRIES(TLB_ENTRIES)) u_random_ctr (
    .clk         (clk),
    .resetn      (resetn),
    .wired_we    (wired_we),
    .wired_wdata (wired_wdata),
    .random      (random),
    .wired       (wired)
  );

  assign op_ready    = (state_q == IDLE) & ~flush;
  assign accept      = op_valid & op_ready;
  assign tlbw_addr   = waddr_q;
  assign tlbra       = tlbra_q;
  assign index_wdata = {~hit_q, (hit_q ? hit_idx_q : {IW{1'b0}})};

  // Next-state and strobe decode. A flush abandons a probe or read before
  // any CP0 state is touched, but a write already on the TLB port finishes.
  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    tlbw_valid = (state_q == WRITE);
    index_we   = (state_q == DONE) && (op_q == TLBP);
    entry_we   = (state_q == DONE) && (op_q == TLBR);
    op_done    = (state_q == DONE) && !suppress_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_type)
            TLBP:    state_d = PROBE;
            TLBR:    state_d = READ;
            default: state_d = WRITE;
          endcase
        end
      end
`ifdef TLB_OP_REG_PROBE_EN
      PROBE:     state_d = flush ? IDLE : PROBE_REG;
`else
      PROBE:     state_d = flush ? IDLE : DONE;
`endif
      PROBE_REG: state_d = flush ? IDLE : DONE;
      READ:      state_d = flush ? IDLE : DONE;
      WRITE:     state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and datapath registers. TLBWR captures Random as it stands in
  // the accept cycle, before any same-cycle Wired write reloads it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      op_q       <= TLBP;
      waddr_q    <= '0;
      tlbra_q    <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      suppress_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= tlb_op_t'(op_type);
        suppress_q <= 1'b0;
        case (op_type)
          TLBWR:   waddr_q <= random;
          TLBWI:   waddr_q <= cp0_index;
          TLBR:    tlbra_q <= cp0_index;
          default: ;
        endcase
      end
      if (state_q == PROBE_SAMPLE) begin
        hit_q     <= probe_hit;
        hit_idx_q <= probe_index;
      end
      if (state_q == WRITE) begin
        suppress_q <= flush;
      end
    end
  end

endmodule
